// File: rtl/sound_event_arbiter.sv
// Synchronises NUM_CH event lines, latches rising edges as pending requests and plays one
// sound at a time for DURATION cycles, lowest index first. Define SOUND_EVENT_PREEMPT_EN for preemption.
module sound_event_arbiter #(
    parameter int               NUM_CH   = 4,
    parameter int               DUR_W    = 16,
    parameter logic [DUR_W-1:0] DURATION = 16'd50000,
    localparam int              CH_W     = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              nRst,
    input  logic [NUM_CH-1:0] event_i,
    input  logic              mute_i,
    output logic              active_o,
    output logic [CH_W-1:0]   ch_o,
    output logic [NUM_CH-1:0] ch_onehot_o,
    output logic              done_o
);

    typedef enum logic {IDLE = 1'b0, PLAY = 1'b1} state_e;

    state_e            state_q, state_d;
    logic [DUR_W-1:0]  cnt_q, cnt_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [NUM_CH-1:0] pend_q, pend_d;
    logic              done_q, done_d;
    logic [NUM_CH-1:0] sync1_q, sync2_q, prev_q;

    logic [NUM_CH-1:0] rise;
    logic [CH_W-1:0]   sel;
    logic              any_pend;
    logic              grant;

    assign rise     = sync2_q & ~prev_q;
    assign any_pend = |pend_q;

    // Lowest-index pending channel wins; scan downward so the last hit is the smallest index.
    always_comb begin
        sel = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (pend_q[i]) sel = CH_W'(i);
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ch_q    <= '0;
            pend_q  <= '0;
            done_q  <= 1'b0;
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ch_q    <= ch_d;
            pend_q  <= pend_d;
            done_q  <= done_d;
            sync1_q <= event_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ch_d    = ch_q;
        done_d  = 1'b0;
        grant   = 1'b0;
        if (mute_i) begin
            state_d = IDLE;
            cnt_d   = '0;
            ch_d    = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_pend) begin
                        state_d = PLAY;
                        ch_d    = sel;
                        cnt_d   = DURATION - DUR_W'(1);
                        grant   = 1'b1;
                    end
                end
                PLAY: begin
`ifdef SOUND_EVENT_PREEMPT_EN
                    if (any_pend && (sel < ch_q)) begin
                        ch_d  = sel;
                        cnt_d = DURATION - DUR_W'(1);
                        grant = 1'b1;
                    end else
`endif
                    if (cnt_q == '0) begin
                        state_d = IDLE;
                        ch_d    = '0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q - DUR_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // A fresh rise beats the grant clear, so a re-triggered channel replays later.
    always_comb begin
        pend_d = '0;
        if (!mute_i) begin
            pend_d = (pend_q & ~(grant ? (NUM_CH'(1) << sel) : '0)) | rise;
        end
    end

    always_comb begin
        active_o    = (state_q == PLAY);
        ch_o        = ch_q;
        ch_onehot_o = (state_q == PLAY) ? (NUM_CH'(1) << ch_q) : '0;
        done_o      = done_q;
    end

endmodule

// File: tb/tb_sound_event_arbiter.sv
// Scoreboard bench for sound_event_arbiter with NUM_CH=4, DURATION=5.
module tb_sound_event_arbiter;

    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;

    logic              clk = 1'b0;
    logic              nRst;
    logic [NUM_CH-1:0] event_i;
    logic              mute_i;
    logic              active_o;
    logic [CH_W-1:0]   ch_o;
    logic [NUM_CH-1:0] ch_onehot_o;
    logic              done_o;

    sound_event_arbiter #(.NUM_CH(NUM_CH), .DUR_W(16), .DURATION(16'd5)) dut (
        .clk(clk), .nRst(nRst), .event_i(event_i), .mute_i(mute_i),
        .active_o(active_o), .ch_o(ch_o), .ch_onehot_o(ch_onehot_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ch;
        int len;
        int done;
        int gap;   // idle cycles before this sound, -1 = don't care
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check_eq(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input int ch, input int len, input int done, input int gap);
        exp_t e;
        e.ch = ch; e.len = len; e.done = done; e.gap = gap;
        return e;
    endfunction

    // Monitor: splits the output stream into sounds and compares each against the scoreboard.
    initial begin
        bit in_seg = 1'b0;
        int seg_ch = 0;
        int seg_len = 0;
        int idle_cnt = 0;
        bit ended;
        exp_t e;
        forever begin
            @(negedge clk);
            ended = 1'b0;
            if (in_seg && (!active_o || int'(ch_o) != seg_ch)) begin
                ended  = 1'b1;
                in_seg = 1'b0;
                if (sb.size() == 0) begin
                    check_eq("sb_unexpected_end", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check_eq("sound_ch", seg_ch, e.ch);
                    check_eq("sound_len", seg_len, e.len);
                    check_eq("sound_done", int'(done_o), e.done);
                end
            end else if (in_seg) begin
                seg_len++;
            end
            if (!ended) check_eq("done_idle", int'(done_o), 0);
            if (!in_seg && active_o) begin
                in_seg  = 1'b1;
                seg_ch  = int'(ch_o);
                seg_len = 1;
                if (sb.size() == 0) check_eq("sb_unexpected_start", 1, 0);
                else if (sb[0].gap >= 0) check_eq("sound_gap", idle_cnt, sb[0].gap);
            end
            idle_cnt = active_o ? 0 : idle_cnt + 1;
            check_eq("onehot", int'(ch_onehot_o), active_o ? (1 << int'(ch_o)) : 0);
            if (!active_o) check_eq("ch_idle", int'(ch_o), 0);
        end
    end

    task automatic pulse(input logic [NUM_CH-1:0] m);
        @(negedge clk) event_i = m;
        @(negedge clk) event_i = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        nRst = 1'b0; event_i = '0; mute_i = 1'b0;
        #13;
        check_eq("rst_active", int'(active_o), 0);
        check_eq("rst_ch", int'(ch_o), 0);
        check_eq("rst_onehot", int'(ch_onehot_o), 0);
        check_eq("rst_done", int'(done_o), 0);
        @(negedge clk) nRst = 1'b1;
        idle(3);

        // Single event on ch 2, with latency checks around E3.
        sb.push_back(mk(2, 5, 1, -1));
        @(negedge clk) event_i = 4'b0100;
        @(posedge clk);
        @(negedge clk) event_i = '0;
        @(posedge clk);
        @(posedge clk); #1;
        check_eq("lat_e2_active", int'(active_o), 0);
        @(posedge clk); #1;
        check_eq("lat_e3_active", int'(active_o), 1);
        check_eq("lat_e3_ch", int'(ch_o), 2);
        check_eq("lat_e3_onehot", int'(ch_onehot_o), 4);
        idle(15);

        // Held level produces exactly one sound.
        sb.push_back(mk(1, 5, 1, -1));
        @(negedge clk) event_i = 4'b0010;
        idle(20);
        event_i = '0;
        idle(15);

        // Simultaneous rises: ch 0 then ch 3 after one idle cycle.
        sb.push_back(mk(0, 5, 1, -1));
        sb.push_back(mk(3, 5, 1, 1));
        pulse(4'b1001);
        idle(25);

        // Higher-priority event during play; rise sampled at the 2nd active cycle.
`ifdef SOUND_EVENT_PREEMPT_EN
        sb.push_back(mk(3, 4, 0, -1));
        sb.push_back(mk(0, 5, 1, 0));
`else
        sb.push_back(mk(3, 5, 1, -1));
        sb.push_back(mk(0, 5, 1, 1));
`endif
        pulse(4'b1000);
        repeat (3) @(posedge clk);
        pulse(4'b0001);
        idle(25);

        // Mute during ch 1 play with ch 2 pending: nothing plays afterwards.
        sb.push_back(mk(1, 3, 0, -1));
        pulse(4'b0110);
        repeat (5) @(posedge clk);
        @(negedge clk) mute_i = 1'b1;
        @(negedge clk) mute_i = 1'b0;
        #1;
        check_eq("mute_active", int'(active_o), 0);
        idle(25);

        // Reset mid-play clears outputs immediately.
        sb.push_back(mk(2, 2, 0, -1));
        pulse(4'b0100);
        repeat (4) @(posedge clk);
        @(negedge clk);
        #2 nRst = 1'b0;
        #1;
        check_eq("rstmid_active", int'(active_o), 0);
        check_eq("rstmid_ch", int'(ch_o), 0);
        check_eq("rstmid_onehot", int'(ch_onehot_o), 0);
        check_eq("rstmid_done", int'(done_o), 0);
        idle(3);
        nRst = 1'b1;
        idle(10);
        check_eq("post_rst_active", int'(active_o), 0);

        // Normal operation after reset.
        sb.push_back(mk(0, 5, 1, -1));
        pulse(4'b0001);
        idle(20);

        check_eq("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
